// File: rtl/packet_post_process_if.sv
// Bundle of the raw-FIFO pop port, verdict handshake, egress AXI-Stream and counter strobes
// of the packet egress stage. The slave modport is the post-processor's view.
interface packet_post_process_if #(
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 128,
    parameter int ID_WIDTH   = 2,
    parameter int AXI_WIDTH  = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int WORD_WIDTH = 1 + ID_WIDTH + USER_WIDTH + STRB_WIDTH + DATA_WIDTH;

    logic [WORD_WIDTH-1:0]   post_fi_raw_fifo_data;
    logic                    post_fi_raw_fifo_empty;
    logic                    post_fo_raw_fifo_rd_en;
    logic                    post_fi_verdict_valid;
    logic                    post_fi_verdict_drop;
    logic [ID_WIDTH-1:0]     post_fi_verdict_id;
    logic                    post_fo_verdict_ready;
    logic [DATA_WIDTH-1:0]   post_fo_m_data;
    logic [STRB_WIDTH-1:0]   post_fo_m_strobe;
    logic [USER_WIDTH-1:0]   post_fo_m_user;
    logic                    post_fo_m_valid;
    logic                    post_fo_m_last;
    logic                    post_fi_m_ready;
    logic                    pkt_out;
    logic [AXI_WIDTH/2-1:0]  byte_out;
    logic                    pkt_drop;
    logic                    id_err;

    modport slave (
        input  post_fi_raw_fifo_data, post_fi_raw_fifo_empty,
        input  post_fi_verdict_valid, post_fi_verdict_drop, post_fi_verdict_id,
        input  post_fi_m_ready,
        output post_fo_raw_fifo_rd_en, post_fo_verdict_ready,
        output post_fo_m_data, post_fo_m_strobe, post_fo_m_user, post_fo_m_valid, post_fo_m_last,
        output pkt_out, byte_out, pkt_drop, id_err
    );

    modport master (
        output post_fi_raw_fifo_data, post_fi_raw_fifo_empty,
        output post_fi_verdict_valid, post_fi_verdict_drop, post_fi_verdict_id,
        output post_fi_m_ready,
        input  post_fo_raw_fifo_rd_en, post_fo_verdict_ready,
        input  post_fo_m_data, post_fo_m_strobe, post_fo_m_user, post_fo_m_valid, post_fo_m_last,
        input  pkt_out, byte_out, pkt_drop, id_err
    );
endinterface

// File: rtl/packet_post_process.sv
// Egress stage of the raw-packet FIFO: waits for a per-packet verdict, then forwards the
// packet through a one-deep AXI-Stream output register or discards it, with counter strobes.
module packet_post_process #(
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 128,
    parameter int ID_WIDTH   = 2,
    parameter int AXI_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    packet_post_process_if.slave bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int WORD_WIDTH = 1 + ID_WIDTH + USER_WIDTH + STRB_WIDTH + DATA_WIDTH;
    localparam int BYTE_WIDTH = AXI_WIDTH / 2;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  m_data_q;
    logic [STRB_WIDTH-1:0]  m_strobe_q;
    logic [USER_WIDTH-1:0]  m_user_q;
    logic                   m_valid_q;
    logic                   m_last_q;
    logic                   m_first_q;
    logic                   first_q;
    logic                   pkt_out_q;
    logic [BYTE_WIDTH-1:0]  byte_out_q;
    logic                   pkt_drop_q;
    logic                   id_err_q;

    logic                   verdict_ready;
    logic                   rd_en;
    logic                   drop_done;
    logic                   id_mismatch;
    logic                   out_free;
    logic                   fwd_pop;
    logic                   beat_taken;

    logic                   head_last;
    logic [ID_WIDTH-1:0]    head_id;
    logic [USER_WIDTH-1:0]  head_user;
    logic [STRB_WIDTH-1:0]  head_strobe;
    logic [DATA_WIDTH-1:0]  head_data;

    assign head_last   = bus.post_fi_raw_fifo_data[WORD_WIDTH-1];
    assign head_id     = bus.post_fi_raw_fifo_data[WORD_WIDTH-2 -: ID_WIDTH];
    assign head_user   = bus.post_fi_raw_fifo_data[DATA_WIDTH+STRB_WIDTH +: USER_WIDTH];
    assign head_strobe = bus.post_fi_raw_fifo_data[DATA_WIDTH +: STRB_WIDTH];
    assign head_data   = bus.post_fi_raw_fifo_data[DATA_WIDTH-1:0];

    assign out_free   = !m_valid_q || bus.post_fi_m_ready;
    assign beat_taken = m_valid_q && bus.post_fi_m_ready;
    assign fwd_pop    = (state_q == FWD) && rd_en;

    always_comb begin
        state_d       = state_q;
        verdict_ready = 1'b0;
        rd_en         = 1'b0;
        drop_done     = 1'b0;
        id_mismatch   = 1'b0;
        case (state_q)
            IDLE: begin
                verdict_ready = !bus.post_fi_raw_fifo_empty;
                if (verdict_ready && bus.post_fi_verdict_valid) begin
                    // ID width is the wrap modulus, so a plain equality compare handles 3 -> 0
                    if (bus.post_fi_verdict_id != head_id) begin
                        state_d     = DROP;
                        id_mismatch = 1'b1;
                    end else if (bus.post_fi_verdict_drop) begin
                        state_d = DROP;
                    end else begin
                        state_d = FWD;
                    end
                end
            end
            FWD: begin
                rd_en = out_free && !bus.post_fi_raw_fifo_empty;
                if (rd_en && head_last) state_d = IDLE;
            end
            DROP: begin
                rd_en = !bus.post_fi_raw_fifo_empty;
                if (rd_en && head_last) begin
                    state_d   = IDLE;
                    drop_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            m_data_q   <= '0;
            m_strobe_q <= '0;
            m_user_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_first_q  <= 1'b0;
            first_q    <= 1'b0;
            pkt_out_q  <= 1'b0;
            byte_out_q <= '0;
            pkt_drop_q <= 1'b0;
            id_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fwd_pop) begin
                m_data_q   <= head_data;
                m_strobe_q <= head_strobe;
                m_user_q   <= head_user;
                m_last_q   <= head_last;
                m_valid_q  <= 1'b1;
                m_first_q  <= first_q;
            end else if (bus.post_fi_m_ready) begin
                m_valid_q <= 1'b0;
            end
            // first_q marks that the next forwarded pop opens a new packet
            if (state_q == IDLE && state_d == FWD) begin
                first_q <= 1'b1;
            end else if (fwd_pop) begin
                first_q <= 1'b0;
            end
            pkt_out_q  <= beat_taken && m_first_q;
            byte_out_q <= (beat_taken && m_first_q) ? m_user_q[BYTE_WIDTH-1:0] : '0;
            pkt_drop_q <= drop_done;
            id_err_q   <= id_mismatch;
        end
    end

    assign bus.post_fo_raw_fifo_rd_en = rd_en;
    assign bus.post_fo_verdict_ready  = verdict_ready;
    assign bus.post_fo_m_data         = m_data_q;
    assign bus.post_fo_m_strobe       = m_strobe_q;
    assign bus.post_fo_m_user         = m_user_q;
    assign bus.post_fo_m_valid        = m_valid_q;
    assign bus.post_fo_m_last         = m_last_q;
    assign bus.pkt_out                = pkt_out_q;
    assign bus.byte_out               = byte_out_q;
    assign bus.pkt_drop               = pkt_drop_q;
    assign bus.id_err                 = id_err_q;
endmodule
